// File: rtl/leaky_relu_stream.sv
// leaky_relu_stream: two-stage valid/ready LeakyReLU on signed samples.
// Stage 1 holds the accepted sample together with the slope that was in
// effect when it was accepted. Stage 2 is the output register. The slope
// multiply and rounding sit between the two stages. A saturating counter
// tracks how many negative samples have been delivered.
module leaky_relu_stream #(
  parameter int                 DATA_W      = 32,
  parameter int                 SLOPE_W     = 16,
  parameter logic [SLOPE_W-1:0] RESET_SLOPE = 16'h028F,
  parameter int                 CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  input  logic               slope_we,
  input  logic [SLOPE_W-1:0] slope_wdata,
  output logic [SLOPE_W-1:0] slope,
  output logic [CNT_W-1:0]   neg_cnt,
  input  logic               cnt_clr
);

  localparam int P_W = DATA_W + SLOPE_W + 1;
  localparam logic [P_W-1:0] HALF = P_W'(1) << (SLOPE_W - 1);

  // Stage 1 state
  logic               s1_valid_reg;
  logic [DATA_W-1:0]  s1_data_reg;
  logic               s1_mode_reg;
  logic [SLOPE_W-1:0] s1_slope_reg;

  // Stage 2 (output) state
  logic               s2_valid_reg;
  logic [DATA_W-1:0]  s2_data_reg;
  logic               s2_neg_reg;

  logic [SLOPE_W-1:0] slope_reg;
  logic [CNT_W-1:0]   neg_cnt_reg;

  logic               s2_adv;
  logic               in_fire;
  logic               out_fire;
  logic               s1_neg;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] prod_rnd;
  logic [DATA_W-1:0]  rnd_data;
  logic [DATA_W-1:0]  y_next;

  // The output register can take new data when it is empty or being drained;
  // stage 1 can take new data when it is empty or moving into stage 2.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_reg && out_ready;
  assign s1_neg   = s1_data_reg[DATA_W-1];

  assign out_valid = s2_valid_reg;
  assign out_data  = s2_data_reg;
  assign slope     = slope_reg;
  assign neg_cnt   = neg_cnt_reg;

  // Scale by the captured slope with round-half-up, then pick the result by
  // sign and mode. Since the slope is below one, the rounded product fits in
  // DATA_W, so truncating to DATA_W keeps it exact.
  always_comb begin
    prod     = P_W'($signed(s1_data_reg)) * P_W'($signed({1'b0, s1_slope_reg}));
    prod_rnd = prod + $signed(HALF);
    rnd_data = DATA_W'(prod_rnd >>> SLOPE_W);
    y_next   = s1_data_reg;
    if (s1_neg) begin
      y_next = s1_mode_reg ? rnd_data : '0;
    end
  end

  // Stage 1: capture the sample, its mode and the slope value in effect
  // when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_mode_reg  <= 1'b0;
      s1_slope_reg <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg  <= in_data;
        s1_mode_reg  <= in_mode;
        s1_slope_reg <= slope_reg;
      end
    end
  end

  // Stage 2: load the computed result. The data is left untouched when no
  // sample arrives, so an empty pipeline keeps its last output value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_neg_reg   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= y_next;
        s2_neg_reg  <= s1_neg;
      end
    end
  end

  // Slope register. Samples already captured keep their own copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slope_reg <= RESET_SLOPE;
    end else if (slope_we) begin
      slope_reg <= slope_wdata;
    end
  end

  // Count negative deliveries and saturate at all-ones. A clear in the same
  // cycle wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt_reg <= '0;
    end else if (cnt_clr) begin
      neg_cnt_reg <= '0;
    end else if (out_fire && s2_neg_reg && (neg_cnt_reg != '1)) begin
      neg_cnt_reg <= neg_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_leaky_relu_stream.sv
// Testbench for leaky_relu_stream: table of directed vectors plus hand-written
// sequences covering backpressure, the slope-write race, the counter and a
// reset in the middle of a stream.
module tb_leaky_relu_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        slope_we;
  logic [15:0] slope_wdata;
  logic [15:0] slope;
  logic [15:0] neg_cnt;
  logic        cnt_clr;

  // Narrow-counter instance that shares every input with the main instance
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic [15:0] slope2;
  logic [1:0]  neg_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  leaky_relu_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .slope_we(slope_we), .slope_wdata(slope_wdata), .slope(slope),
    .neg_cnt(neg_cnt), .cnt_clr(cnt_clr)
  );

  leaky_relu_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .slope_we(slope_we), .slope_wdata(slope_wdata), .slope(slope2),
    .neg_cnt(neg_cnt2), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [31:0] x;
    logic        mode;
    logic [15:0] slp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic set_slope(input logic [15:0] v);
    @(negedge clk);
    slope_we    = 1'b1;
    slope_wdata = v;
    @(posedge clk);
    #1;
    slope_we = 1'b0;
    chk("slope_write", 64'(slope), 64'(v));
  endtask

  // One sample through an empty pipeline with out_ready held high.
  // clr asserts cnt_clr on the cycle the output is delivered.
  task automatic run_one(input string name, input logic [31:0] x, input logic mode,
                         input logic [31:0] exp, input logic clr, input logic chk_lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = x;
    in_mode   = mode;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (chk_lat) chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_data"}, 64'(out_data), 64'(exp));
    cnt_clr = clr;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  // Backpressure stimulus
  logic [31:0] bp_x[8];
  logic        bp_m[8];
  logic [31:0] bp_e[8];
  logic [63:0] rdy_pat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b0; slope_we = 1'b0; slope_wdata = '0; cnt_clr = 1'b0;

    vecs[0]  = '{32'h00010000, 1'b1, 16'h4000, 32'h00010000};
    vecs[1]  = '{32'hFFFF0000, 1'b1, 16'h4000, 32'hFFFFC000};
    vecs[2]  = '{32'hFFFFFFFD, 1'b1, 16'h4000, 32'hFFFFFFFF};
    vecs[3]  = '{32'h80000000, 1'b0, 16'h4000, 32'h00000000};
    vecs[4]  = '{32'h80000000, 1'b1, 16'h4000, 32'hE0000000};
    vecs[5]  = '{32'h80000000, 1'b1, 16'hFFFF, 32'h80008000};
    vecs[6]  = '{32'hFFFFFFFC, 1'b0, 16'hFFFF, 32'h00000000};
    vecs[7]  = '{32'h00000000, 1'b1, 16'hFFFF, 32'h00000000};
    vecs[8]  = '{32'h7FFFFFFF, 1'b0, 16'h8000, 32'h7FFFFFFF};
    vecs[9]  = '{32'hFFFFFFFF, 1'b1, 16'h8000, 32'h00000000};
    vecs[10] = '{32'hFFFFFFFD, 1'b1, 16'h8000, 32'hFFFFFFFF};

    bp_x = '{32'h00000010, 32'hFFFFFFF0, 32'h00000100, 32'hFFFFFF00,
             32'hFFFFFFF8, 32'h12345678, 32'hFFFFFFFE, 32'h80000000};
    bp_m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bp_e = '{32'h00000010, 32'hFFFFFFFC, 32'h00000100, 32'hFFFFFFC0,
             32'h00000000, 32'h12345678, 32'h00000000, 32'hE0000000};
    rdy_pat = 64'hFFFF_FFFF_B5C3_3250;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_slope", 64'(slope), 64'h028F);
    chk("rst_neg_cnt", 64'(neg_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      if (slope != vecs[i].slp) set_slope(vecs[i].slp);
      run_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].mode, vecs[i].exp, 1'b0, i == 0);
    end

    // Slope write in the same cycle as an accept
    set_slope(16'h4000);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hFFFFFFFC; in_mode = 1'b1; out_ready = 1'b1;
    slope_we = 1'b1; slope_wdata = 16'h8000;
    @(posedge clk);
    #1;
    slope_we = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("race_first", 64'(out_data), 64'hFFFFFFFF);
    chk("race_slope", 64'(slope), 64'h8000);
    @(posedge clk);
    #1;
    chk("race_second_valid", 64'(out_valid), 64'd1);
    chk("race_second", 64'(out_data), 64'hFFFFFFFE);
    @(posedge clk);
    #1;

    // Backpressure: 8 samples at full rate with out_ready on a fixed pattern
    set_slope(16'h4000);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    begin
      int sent = 0, got = 0, occ = 0, cyc = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      in_valid = 1'b1; in_data = bp_x[0]; in_mode = bp_m[0];
      while (got < 8 && cyc < 200) begin
        out_ready = (cyc < 64) ? rdy_pat[cyc] : 1'b1;
        #1;
        if (prev_stall) begin
          chk("bp_stall_valid", 64'(out_valid), 64'd1);
          chk("bp_stall_data", 64'(out_data), 64'(prev_data));
        end
        chk("bp_in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
        if (out_valid && out_ready) begin
          chk($sformatf("bp_out%0d", got), 64'(out_data), 64'(bp_e[got]));
          got++;
          occ--;
        end
        if (in_valid && in_ready) begin
          sent++;
          occ++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(negedge clk);
        in_valid = (sent < 8);
        if (sent < 8) begin
          in_data = bp_x[sent];
          in_mode = bp_m[sent];
        end
        cyc++;
      end
      if (got < 8) begin
        failures++;
        $display("FAIL bp_timeout: got %0d outputs expected 8", got);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drained", 64'(out_valid), 64'd0);
    end
    chk("cnt_five", 64'(neg_cnt), 64'd5);
    chk("cnt2_sat_a", 64'(neg_cnt2), 64'd3);

    // Clear together with a negative delivery
    run_one("clr_hs", 32'hFFFFFFF0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
    chk("cnt_clr_prio", 64'(neg_cnt), 64'd0);
    chk("cnt2_clr_prio", 64'(neg_cnt2), 64'd0);

    // Six negatives: narrow counter saturates
    for (int i = 0; i < 6; i++) begin
      run_one($sformatf("neg%0d", i), 32'hFFFFFF00, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("cnt_six", 64'(neg_cnt), 64'd6);
    chk("cnt2_sat_b", 64'(neg_cnt2), 64'd3);

    // Reset with both stages full and output stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000011; in_mode = 1'b1;
    @(negedge clk);
    in_data = 32'h00000022;
    @(negedge clk);
    in_data = 32'h00000033;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_slope", 64'(slope), 64'h028F);
    chk("mid_rst_neg_cnt", 64'(neg_cnt), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("after_rst", 32'hFFFF0000, 1'b1, 32'hFFFFFD71, 1'b0, 1'b1);
    chk("after_rst_cnt", 64'(neg_cnt), 64'd1);
    chk("after_rst_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
